rr_arbiter_hs: RTL and testbench
================================

RR_ARBITER_HS -- requirements
Module: rr_arbiter_hs

Interface
REQ-001 SHALL have parameter REQ_NB, default 4: number of requesters; legal range 2..32.
REQ-002 SHALL have parameter MAX_HOLD, default 16: maximum number of cycles one grant is held; 0 means unlimited.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: permits new grant decisions.
REQ-006 SHALL have port req, input, REQ_NB bits: request vector, one bit per requester.
REQ-007 SHALL have port done, input, 1 bit: the granted requester ends its transaction this cycle.
REQ-008 SHALL have port grant, output, REQ_NB bits: registered one-hot grant; all-zero when nothing is granted.
REQ-009 SHALL have port grant_vld, output, 1 bit: equals OR of grant.
REQ-010 SHALL have port grant_id, output, $clog2(REQ_NB) bits: index of the granted requester; 0 when grant_vld=0.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (no grant) and BUSY (grant held).
REQ-012 SHALL keep a pointer ptr (index of the highest-priority requester); the winner is the first set req bit scanning ptr, ptr+1, ..., REQ_NB-1, 0, ..., ptr-1 (wrap-around).
REQ-013 IDLE: when en=1 and |req=1, SHALL register the winner into grant and enter BUSY; latency is 1 cycle from sampled req to grant.
REQ-014 IDLE: when en=0 or req is all-zero, SHALL keep grant=0 and remain in IDLE.
REQ-015 BUSY: SHALL hold grant unchanged, independent of en and of other req bits, until a release event.
REQ-016 Release event SHALL be any of: done=1; req[grant_id]=0; or MAX_HOLD!=0 and hold count reaches MAX_HOLD-1.
REQ-017 On release, SHALL set ptr=(grant_id+1) mod REQ_NB in the same edge.
REQ-018 On release, if en=1 and any req is set, SHALL grant the winner computed with the new ptr in the same edge (no idle bubble) and stay in BUSY.
REQ-019 On release with en=0 or no req, SHALL clear grant and enter IDLE.
REQ-020 Sole requester on release with en=1: SHALL be re-granted immediately.
REQ-021 The hold counter SHALL reset to 0 on every new grant, increment each BUSY cycle, and saturate (no wrap).
REQ-022 Simultaneous release causes SHALL be treated as a single release.
REQ-023 grant SHALL never have more than one bit set.

Reset
REQ-024 While rst_i=1, SHALL immediately set grant=0, grant_vld=0, grant_id=0, ptr=0, hold count=0 and FSM=IDLE, even mid-grant.
REQ-025 After rst_i deasserts, the first grant SHALL occur no earlier than the first rising edge with en=1 and |req=1.

Configuration
REQ-026 With RR_ARB_PRIORITY_EN defined, SHALL add input port prio (2*REQ_NB bits, 2 bits per requester; 3 = highest), and only active requesters whose priority equals the maximum active priority SHALL enter the round-robin scan; ptr is shared across levels.
REQ-027 Without RR_ARB_PRIORITY_EN, port prio SHALL be absent and all requesters SHALL have equal priority.

Verification
REQ-028 REQ_NB=4, req=1111 held, done pulsed every cycle while granted -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-029 REQ_NB=4, req=1101, done every cycle -> grants cycle 0001, 0100, 1000; 0010 is never granted.
REQ-030 MAX_HOLD=4, req=0011, done=0 -> 0001 held exactly 4 cycles, then 0010 granted with no bubble.
REQ-031 Grant 0100 active, en=0, done=1 -> grant=0000 next cycle; en=1 later -> 1000 granted (ptr=3).
REQ-032 rst_i asserted mid-BUSY -> grant=0 asynchronously; after release with req=1111, en=1 -> first grant 0001.
REQ-033 RR_ARB_PRIORITY_EN defined, prio[2]=3 and others 0, req=1111, done every cycle -> 0100 repeatedly; drop req[2] -> 1000, then 0001.

Source files
------------

// File: rtl/rr_arbiter_hs_if.sv
// Request/grant bundle for rr_arbiter_hs. The prio field and its modport entries
// exist only when RR_ARB_PRIORITY_EN is defined.
//
// Handshake: req[i] is held high by requester i until it has been served.
// grant is the arbiter's acceptance: one-hot and registered.
// The granted transaction ends in the cycle where done=1 is sampled while grant_vld=1,
// or when the granted requester drops its req bit.
// en only gates new grant decisions; it never revokes a grant that is already held.
interface rr_arbiter_hs_if #(
  parameter int REQ_NB = 4
);
  localparam int IDW = (REQ_NB > 1) ? $clog2(REQ_NB) : 1;

  logic              en;
  logic [REQ_NB-1:0] req;
  logic              done;
  logic [REQ_NB-1:0] grant;
  logic              grant_vld;
  logic [IDW-1:0]    grant_id;
  logic [0:0]        state;

`ifdef RR_ARB_PRIORITY_EN
  logic [2*REQ_NB-1:0] prio;

  modport master (
    input  en, req, done, prio,
    output grant, grant_vld, grant_id, state
  );

  modport slave (
    output en, req, done, prio,
    input  grant, grant_vld, grant_id, state
  );
`else
  modport master (
    input  en, req, done,
    output grant, grant_vld, grant_id, state
  );

  modport slave (
    output en, req, done,
    input  grant, grant_vld, grant_id, state
  );
`endif

endinterface

// File: rtl/rr_arbiter_hs.sv
// Round-robin arbiter with a held grant, release on done, on a dropped request or on hold timeout.
// Define RR_ARB_PRIORITY_EN to add 2-bit per-requester priority levels ahead of the round-robin scan.
module rr_arbiter_hs #(
  parameter int REQ_NB   = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  rr_arbiter_hs_if.master bus
);

  localparam int IDW = (REQ_NB > 1) ? $clog2(REQ_NB) : 1;
  localparam int HW  = $clog2(MAX_HOLD + 2);

  localparam bit            HOLD_LIMITED = (MAX_HOLD != 0);
  localparam logic [HW-1:0] HOLD_LAST    = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_SAT     = {HW{1'b1}};
  localparam logic [IDW-1:0] ID_MAX      = IDW'(REQ_NB - 1);
  localparam logic [REQ_NB-1:0] ONE      = {{(REQ_NB-1){1'b0}}, 1'b1};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state_q, state_n;
  logic [REQ_NB-1:0] grant_q, grant_n;
  logic [IDW-1:0]    id_q, id_n;
  logic [IDW-1:0]    ptr_q, ptr_n;
  logic [HW-1:0]     hold_q, hold_n;

  logic [REQ_NB-1:0] eligible;
  logic [IDW-1:0]    id_inc;
  logic [IDW-1:0]    scan_base;
  logic              release_evt;
  logic              win_found;
  logic [IDW-1:0]    win_id;

  // Requesters that may take part in this cycle's round-robin scan.
`ifdef RR_ARB_PRIORITY_EN
  logic [1:0] max_prio;

  always_comb begin
    max_prio = 2'd0;
    for (int i = 0; i < REQ_NB; i++) begin
      if (bus.req[i] && (bus.prio[2*i +: 2] > max_prio)) begin
        max_prio = bus.prio[2*i +: 2];
      end
    end
    eligible = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      eligible[i] = bus.req[i] && (bus.prio[2*i +: 2] == max_prio);
    end
  end
`else
  always_comb begin
    eligible = bus.req;
  end
`endif

  assign id_inc = (id_q == ID_MAX) ? '0 : id_q + 1'b1;

  // Release: any cause ends the grant, so simultaneous causes count only once.
  assign release_evt = (state_q == ST_BUSY) &&
                       (bus.done || !bus.req[id_q] ||
                        (HOLD_LIMITED && (hold_q == HOLD_LAST)));

  // On release the scan starts from the pointer value being written in this edge.
  assign scan_base = (state_q == ST_BUSY) ? id_inc : ptr_q;

  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_v;
    idx       = 0;
    idx_v     = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < REQ_NB; k++) begin
      idx = int'(scan_base) + k;
      if (idx >= REQ_NB) begin
        idx = idx - REQ_NB;
      end
      idx_v = IDW'(idx);
      if (!win_found && eligible[idx_v]) begin
        win_found = 1'b1;
        win_id    = idx_v;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    id_n    = id_q;
    ptr_n   = ptr_q;
    hold_n  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.en && win_found) begin
          state_n = ST_BUSY;
          grant_n = ONE << win_id;
          id_n    = win_id;
          hold_n  = '0;
        end
      end
      ST_BUSY: begin
        if (release_evt) begin
          ptr_n = id_inc;
          if (bus.en && win_found) begin
            grant_n = ONE << win_id;
            id_n    = win_id;
            hold_n  = '0;
          end else begin
            state_n = ST_IDLE;
            grant_n = '0;
            id_n    = '0;
            hold_n  = '0;
          end
        end else if (hold_q != HOLD_SAT) begin
          hold_n = hold_q + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
        id_n    = '0;
        hold_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      id_q    <= id_n;
      ptr_q   <= ptr_n;
      hold_q  <= hold_n;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_vld = |grant_q;
  assign bus.grant_id  = id_q;
  assign bus.state     = state_q;

  a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(grant_q));
  a_state_match:  assert property (@(posedge clk_i) disable iff (rst_i)
                                   ((state_q == ST_BUSY) == (|grant_q)));

endmodule

// File: tb/tb_rr_arbiter_hs.sv
// Directed bench for rr_arbiter_hs (REQ_NB=4, MAX_HOLD=4): vector table plus reset and priority sequences.
module tb_rr_arbiter_hs;

  localparam int REQ_NB   = 4;
  localparam int MAX_HOLD = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  always #5 clk_i = ~clk_i;

  rr_arbiter_hs_if #(.REQ_NB(REQ_NB)) bus ();

  rr_arbiter_hs #(.REQ_NB(REQ_NB), .MAX_HOLD(MAX_HOLD)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] exp_grant;
  } vec_t;

  localparam int NVEC = 25;
  vec_t       vecs[NVEC];
  logic [3:0] exp_q[$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot_id(input logic [3:0] g);
    for (int i = 0; i < 4; i++) begin
      if (g[i]) return 2'(i);
    end
    return 2'd0;
  endfunction

  task automatic check_grant(input string name, input logic [3:0] exp);
    check({name, " grant"}, 32'(bus.grant), 32'(exp));
    check({name, " grant_vld"}, 32'(bus.grant_vld), 32'(|exp));
    check({name, " grant_id"}, 32'(bus.grant_id), 32'(onehot_id(exp)));
  endtask

  task automatic drive(input logic en, input logic [3:0] req, input logic done);
    @(negedge clk_i);
    bus.en   = en;
    bus.req  = req;
    bus.done = done;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bus.en   = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
`ifdef RR_ARB_PRIORITY_EN
    bus.prio = '0;
`endif

    //        en    req      done  exp_grant
    vecs[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0001};
    vecs[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0010};
    vecs[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0100};
    vecs[3]  = '{1'b1, 4'b1111, 1'b1, 4'b1000};
    vecs[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0001};
    vecs[5]  = '{1'b1, 4'b1101, 1'b1, 4'b0100};
    vecs[6]  = '{1'b1, 4'b1101, 1'b1, 4'b1000};
    vecs[7]  = '{1'b1, 4'b1101, 1'b1, 4'b0001};
    vecs[8]  = '{1'b1, 4'b1101, 1'b1, 4'b0100};
    vecs[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0000};
    vecs[10] = '{1'b0, 4'b1111, 1'b0, 4'b0000};
    vecs[11] = '{1'b1, 4'b1111, 1'b0, 4'b1000};
    vecs[12] = '{1'b1, 4'b1111, 1'b0, 4'b1000};
    vecs[13] = '{1'b1, 4'b1111, 1'b0, 4'b1000};
    vecs[14] = '{1'b1, 4'b1111, 1'b0, 4'b1000};
    vecs[15] = '{1'b1, 4'b1111, 1'b0, 4'b0001};
    vecs[16] = '{1'b1, 4'b0011, 1'b0, 4'b0001};
    vecs[17] = '{1'b1, 4'b0011, 1'b0, 4'b0001};
    vecs[18] = '{1'b1, 4'b0011, 1'b0, 4'b0001};
    vecs[19] = '{1'b1, 4'b0011, 1'b0, 4'b0010};
    vecs[20] = '{1'b1, 4'b0001, 1'b0, 4'b0001};
    vecs[21] = '{1'b0, 4'b0001, 1'b0, 4'b0001};
    vecs[22] = '{1'b1, 4'b0001, 1'b1, 4'b0001};
    vecs[23] = '{1'b1, 4'b0000, 1'b0, 4'b0000};
    vecs[24] = '{1'b1, 4'b0000, 1'b0, 4'b0000};

    // Reset state, including while requests are already present.
    #2 rst_i = 1'b1;
    #1 check_grant("reset", 4'b0000);
    check("reset state", 32'(bus.state), 32'd0);
    bus.en  = 1'b1;
    bus.req = 4'b1111;
    @(posedge clk_i);
    #1 check_grant("in reset", 4'b0000);
    @(negedge clk_i);
    rst_i  = 1'b0;
    bus.en = 1'b0;
    drive(1'b0, 4'b1111, 1'b0);
    check_grant("post reset en0", 4'b0000);

    for (int i = 0; i < NVEC; i++) begin
      logic [3:0] exp;
      exp_q.push_back(vecs[i].exp_grant);
      drive(vecs[i].en, vecs[i].req, vecs[i].done);
      exp = exp_q.pop_front();
      check_grant($sformatf("row%0d", i), exp);
    end

    // Asynchronous reset in the middle of a held grant; ptr must return to 0.
    drive(1'b1, 4'b1111, 1'b0);
    check_grant("pre reset busy", 4'b0010);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 check_grant("async reset", 4'b0000);
    check("async reset state", 32'(bus.state), 32'd0);
    @(posedge clk_i);
    #1 check_grant("held reset", 4'b0000);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1 check_grant("first after reset", 4'b0001);
    check("busy state", 32'(bus.state), 32'd1);

`ifdef RR_ARB_PRIORITY_EN
    @(negedge clk_i);
    rst_i = 1'b1;
    bus.prio = 8'b00_11_00_00;
    #2 rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b1111, 1'b1);
      check_grant($sformatf("prio hi %0d", i), 4'b0100);
    end
    drive(1'b1, 4'b1011, 1'b1);
    check_grant("prio drop a", 4'b1000);
    drive(1'b1, 4'b1011, 1'b1);
    check_grant("prio drop b", 4'b0001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
